// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sampler: controller states, phase-length minimums
// and default sizing.
package trng_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CELL_RST,
      ST_EXCITE,
      ST_SAMPLE,
      ST_VALID
   } trng_state_t;

   localparam int DEF_NUM_CELLS = 8;
   localparam int DEF_WORD_W    = 32;
   localparam int DEF_REP_LIMIT = 16;

   // The settle minimum of 2 covers the two-flop synchronizer latency.
   localparam logic [3:0] MIN_RESET_CYCLES  = 4'd1;
   localparam logic [3:0] MIN_SETTLE_CYCLES = 4'd2;

   function automatic logic [3:0] eff_cycles(input logic [3:0] cfg, input logic [3:0] min_val);
      return (cfg < min_val) ? min_val : cfg;
   endfunction

endpackage

// File: rtl/trng_sampler_ctrl_if.sv
// Random-word output stream: word plus valid/ready handshake.
interface trng_sampler_ctrl_if
   import trng_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
);
   logic [WORD_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_sync2.sv
// Two-flop synchronizer bringing the asynchronous cell outputs into the clk domain.
module trng_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/trng_sampler_ctrl.sv
// Sequences entropy cells through reset/excite/sample phases, packs XOR-reduced samples
// into words and keeps a sticky repetition-count health flag.
module trng_sampler_ctrl
   import trng_pkg::*;
#(
   parameter int NUM_CELLS = DEF_NUM_CELLS,
   parameter int WORD_W    = DEF_WORD_W,
   parameter int REP_LIMIT = DEF_REP_LIMIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [3:0]           cfg_reset_cycles,
   input  logic [3:0]           cfg_settle_cycles,
   output logic [NUM_CELLS-1:0] cell_t,
   output logic [NUM_CELLS-1:0] cell_i1,
   output logic [NUM_CELLS-1:0] cell_i2,
   input  logic [NUM_CELLS-1:0] cell_entropy,
   trng_sampler_ctrl_if.master  word_if,
   output logic                 busy,
   output logic                 health_fail,
   input  logic                 health_clr
);
   localparam int BIT_CNT_W = $clog2(WORD_W + 1);
   localparam int REP_CNT_W = $clog2(REP_LIMIT + 1);

   trng_state_t          state_q, state_d;
   logic [3:0]           phase_cnt_q, phase_cnt_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0]    data_q, data_d;
   logic [REP_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic                 health_q;
   logic                 health_set;
   logic [NUM_CELLS-1:0] entropy_sync;
   logic                 sample_bit;
   logic [3:0]           reset_load, settle_load;

   trng_sync2 #(.WIDTH(NUM_CELLS)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (cell_entropy),
      .q_o (entropy_sync)
   );

   assign sample_bit  = ^entropy_sync;
   // Phase counters run down to zero, so load one less than the clamped length.
   assign reset_load  = eff_cycles(cfg_reset_cycles, MIN_RESET_CYCLES) - 4'd1;
   assign settle_load = eff_cycles(cfg_settle_cycles, MIN_SETTLE_CYCLES) - 4'd1;

   always_comb begin
      state_d     = state_q;
      phase_cnt_d = phase_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      data_d      = data_q;
      rep_cnt_d   = rep_cnt_q;
      health_set  = 1'b0;
      cell_t      = '0;
      cell_i1     = '0;
      cell_i2     = '0;
      unique case (state_q)
         ST_IDLE: begin
            bit_cnt_d = '0;
            rep_cnt_d = '0;
            if (enable) begin
               state_d     = ST_CELL_RST;
               phase_cnt_d = reset_load;
            end
         end
         ST_CELL_RST: begin
            cell_i1 = '1;
            if (!enable) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
            end else if (phase_cnt_q == 4'd0) begin
               state_d     = ST_EXCITE;
               phase_cnt_d = settle_load;
            end else begin
               phase_cnt_d = phase_cnt_q - 4'd1;
            end
         end
         ST_EXCITE: begin
            cell_t  = '1;
            cell_i1 = '1;
            if (!enable) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
            end else if (phase_cnt_q == 4'd0) begin
               state_d = ST_SAMPLE;
            end else begin
               phase_cnt_d = phase_cnt_q - 4'd1;
            end
         end
         ST_SAMPLE: begin
            cell_i1 = '1;
            if (!enable) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
            end else begin
               data_d = {data_q[WORD_W-2:0], sample_bit};
               // A zero count means no previous bit since IDLE; data_q[0] holds the last one.
               if (rep_cnt_q == '0 || sample_bit != data_q[0]) begin
                  rep_cnt_d = REP_CNT_W'(1);
               end else if (rep_cnt_q != REP_CNT_W'(REP_LIMIT)) begin
                  rep_cnt_d = rep_cnt_q + REP_CNT_W'(1);
               end
               health_set = (rep_cnt_d == REP_CNT_W'(REP_LIMIT));
               if (bit_cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
                  state_d   = ST_VALID;
                  bit_cnt_d = '0;
               end else begin
                  state_d     = ST_CELL_RST;
                  bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
                  phase_cnt_d = reset_load;
               end
            end
         end
         ST_VALID: begin
            if (word_if.data_ready) begin
               if (enable) begin
                  state_d     = ST_CELL_RST;
                  phase_cnt_d = reset_load;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         phase_cnt_q <= '0;
         bit_cnt_q   <= '0;
         data_q      <= '0;
         rep_cnt_q   <= '0;
         health_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_cnt_q <= phase_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         data_q      <= data_d;
         rep_cnt_q   <= rep_cnt_d;
         if (health_set) begin
            health_q <= 1'b1;
         end else if (health_clr) begin
            health_q <= 1'b0;
         end
      end
   end

   assign word_if.data_out   = data_q;
   assign word_if.data_valid = (state_q == ST_VALID);
   assign busy               = (state_q != ST_IDLE);
   assign health_fail        = health_q;
endmodule

// File: tb/tb_trng_sampler_ctrl.sv
// Directed bench for trng_sampler_ctrl: a timeline model of the bit schedule is checked
// every cycle, plus literal expectations for latency, words and health behaviour.
module tb_trng_sampler_ctrl;
   localparam int NC = 8;
   localparam int WW = 32;
   localparam int RL = 16;
   localparam int M_IDLE = 0, M_GEN = 1, M_VALID = 2;

   logic          clk = 1'b0;
   logic          rst, enable, health_clr;
   logic [3:0]    cfg_r, cfg_s;
   logic [NC-1:0] cell_t, cell_i1, cell_i2, cell_entropy;
   logic          busy, health_fail;
   logic [NC-1:0] live_mask = 8'hFF;
   logic [31:0]   pat = 32'h0;

   int n_vec = 0;
   int n_err = 0;

   trng_sampler_ctrl_if #(.WORD_W(WW)) word_if ();

   trng_sampler_ctrl #(.NUM_CELLS(NC), .WORD_W(WW), .REP_LIMIT(RL)) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .cfg_reset_cycles  (cfg_r),
      .cfg_settle_cycles (cfg_s),
      .cell_t            (cell_t),
      .cell_i1           (cell_i1),
      .cell_i2           (cell_i2),
      .cell_entropy      (cell_entropy),
      .word_if           (word_if),
      .busy              (busy),
      .health_fail       (health_fail),
      .health_clr        (health_clr)
   );

   always #5 clk = ~clk;

   // Cell model out = T & I1 & ~I2; cleared mask bits model dead cells, so the
   // XOR of a 0x7F mask is 1 and of 0xFF is 0.
   assign cell_entropy = cell_t & cell_i1 & ~cell_i2 & live_mask;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff(input int v, input int mn);
      return (v < mn) ? mn : v;
   endfunction

   // ---------------- model: inputs seen at each rising edge ----------------
   logic s_rst = 1'b1, s_en = 1'b0, s_rdy = 1'b0, s_clr = 1'b0;
   int   s_cr = 0, s_cs = 0;

   initial forever begin
      @(posedge clk);
      s_rst = rst; s_en = enable; s_rdy = word_if.data_ready; s_clr = health_clr;
      s_cr = int'(cfg_r); s_cs = int'(cfg_s);
   end

   int          m_mode = M_IDLE, m_t = 0, m_bits = 0, m_R = 1, m_S = 2, m_run = 0;
   logic        m_last = 1'b0, m_health = 1'b0;
   logic [31:0] m_word = 32'h0;

   // Bit schedule within a word: t in [0,R) reset, [R,R+S) excite, t==R+S sample.
   initial forever begin
      logic b, set;
      @(negedge clk);
      set = 1'b0;
      if (s_rst) begin
         m_mode = M_IDLE; m_word = 32'h0; m_health = 1'b0; m_run = 0; m_bits = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_run = 0;
               if (s_en) begin m_mode = M_GEN; m_t = 0; m_bits = 0; m_R = eff(s_cr, 1); end
            end
            M_GEN: begin
               if (!s_en) begin
                  m_mode = M_IDLE; m_bits = 0;
               end else if (m_t == m_R + m_S) begin
                  b = ^live_mask;
                  m_word = {m_word[30:0], b};
                  m_run = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
                  m_last = b;
                  set = (m_run >= RL);
                  m_bits++;
                  if (m_bits == WW) begin m_mode = M_VALID; m_bits = 0; end
                  else begin m_t = 0; m_R = eff(s_cr, 1); end
               end else begin
                  m_t++;
                  if (m_t == m_R) m_S = eff(s_cs, 2);
               end
            end
            default: begin
               if (s_rdy) begin
                  if (s_en) begin m_mode = M_GEN; m_t = 0; m_R = eff(s_cr, 1); end
                  else m_mode = M_IDLE;
               end
            end
         endcase
         if (set) m_health = 1'b1;
         else if (s_clr) m_health = 1'b0;
      end
      if (m_mode == M_GEN && m_t == 0) live_mask = pat[31 - m_bits] ? 8'h7F : 8'hFF;

      check("busy", 32'(busy), 32'(m_mode != M_IDLE));
      check("data_valid", 32'(word_if.data_valid), 32'(m_mode == M_VALID));
      check("data_out", word_if.data_out, m_word);
      check("health_fail", 32'(health_fail), 32'(m_health));
      check("cell_t", 32'(cell_t),
            (m_mode == M_GEN && m_t >= m_R && m_t < m_R + m_S) ? 32'hFF : 32'h0);
      check("cell_i1", 32'(cell_i1), (m_mode == M_GEN) ? 32'hFF : 32'h0);
      check("cell_i2", 32'(cell_i2), 32'h0);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles before data_valid rises and the busy cycle where health_fail first shows.
   task automatic wait_valid(input int max_cyc, output int busy_cyc, output int health_at);
      bit done;
      done = 1'b0;
      busy_cyc = 0;
      health_at = 0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         tick();
         if (word_if.data_valid) done = 1'b1;
         else begin
            if (busy) busy_cyc++;
            if (health_fail && health_at == 0) health_at = busy_cyc;
         end
      end
      if (!done) check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic accept(input logic keep_enable);
      word_if.data_ready = 1'b1;
      enable = keep_enable;
      tick();
      word_if.data_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(word_if.data_valid), 32'd0);
      check({tag, "_data"}, word_if.data_out, 32'h0);
      check({tag, "_health"}, 32'(health_fail), 32'd0);
      check({tag, "_cells"}, {8'h0, cell_t, cell_i1, cell_i2}, 32'h0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bc, ha, cnt;
      rst = 1'b1; enable = 1'b0; health_clr = 1'b0; cfg_r = 4'd1; cfg_s = 4'd2;
      word_if.data_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // 8 live cells: even parity, all-zero word, repetition trip at bit 16.
      pat = 32'h0000_0000;
      enable = 1'b1;
      wait_valid(400, bc, ha);
      check("r1s2_cycles", 32'(bc), 32'd128);
      check("zero_word", word_if.data_out, 32'h0000_0000);
      check("trip_cycle", 32'(ha), 32'd65);
      check("trip_flag", 32'(health_fail), 32'd1);
      accept(1'b0);
      check("idle_after_accept", 32'(busy), 32'd0);
      health_clr = 1'b1; tick(); health_clr = 1'b0;
      check("health_cleared", 32'(health_fail), 32'd0);

      // 7 live cells: odd parity, all-ones word held under back-pressure.
      pat = 32'hFFFF_FFFF;
      enable = 1'b1;
      wait_valid(400, bc, ha);
      check("ones_cycles", 32'(bc), 32'd128);
      check("ones_word", word_if.data_out, 32'hFFFF_FFFF);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", 32'(word_if.data_valid), 32'd1);
         check("hold_word", word_if.data_out, 32'hFFFF_FFFF);
      end
      accept(1'b1);
      check("restart_valid", 32'(word_if.data_valid), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      enable = 1'b0; tick();
      check("drop_in_rst", 32'(busy), 32'd0);
      health_clr = 1'b1; tick(); health_clr = 1'b0;

      // Clamped phases: 1 + 2 + 1 = 4 cycles per bit.
      cfg_r = 4'd0; cfg_s = 4'd0; pat = 32'hA5C3_0F96;
      enable = 1'b1;
      wait_valid(400, bc, ha);
      check("clamp_cycles", 32'(bc), 32'd128);
      check("mixed_word", word_if.data_out, 32'hA5C3_0F96);
      check("mixed_health", 32'(health_fail), 32'd0);
      accept(1'b0);

      // 3 + 5 + 1 = 9 cycles per bit.
      cfg_r = 4'd3; cfg_s = 4'd5; pat = 32'h1234_ABCD;
      enable = 1'b1;
      wait_valid(700, bc, ha);
      check("r3s5_cycles", 32'(bc), 32'd288);
      check("r3s5_word", word_if.data_out, 32'h1234_ABCD);
      accept(1'b0);

      // Enable dropped after 10 complete bits, then a fresh full word.
      cfg_r = 4'd1; cfg_s = 4'd2; pat = 32'h0F0F_0F0F;
      enable = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200 && cnt < 41; i++) begin
         tick();
         if (busy) cnt++;
      end
      check("reached_bit11", 32'(cnt), 32'd41);
      enable = 1'b0;
      tick();
      check("idle_after_drop", 32'(busy), 32'd0);
      repeat (3) begin
         tick();
         check("no_partial_valid", 32'(word_if.data_valid), 32'd0);
      end
      enable = 1'b1;
      wait_valid(400, bc, ha);
      check("reenable_cycles", 32'(bc), 32'd128);
      check("reenable_word", word_if.data_out, 32'h0F0F_0F0F);
      accept(1'b0);

      // Clear coinciding with the trip loses; a lone clear then works; reset mid-word.
      pat = 32'hFFFF_0000;
      enable = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200 && cnt < 64; i++) begin
         tick();
         if (busy) cnt++;
      end
      check("pre_trip_flag", 32'(health_fail), 32'd0);
      health_clr = 1'b1; tick(); health_clr = 1'b0;
      check("set_beats_clear", 32'(health_fail), 32'd1);
      health_clr = 1'b1; tick(); health_clr = 1'b0;
      check("lone_clear", 32'(health_fail), 32'd0);
      repeat (14) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("midword_rst");
      rst = 1'b0;
      enable = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
